bch_bm_solver: RTL and testbench

Inversionless Berlekamp-Massey (binary simplified iBM) key-equation solver for the t=12 BCH decoder over GF(2^16). It sits between the syndrome stage and the Chien search. It takes the 24 syndromes S1..S24 and produces the error-locator coefficients miu0..miu12. It raises a level-valid that drives the Chien search's `enablechian`. Coefficients are scaled by an arbitrary nonzero constant, which is acceptable because the Chien search only tests for roots.

---
 rtl/bch_pkg.sv | 8 +
 rtl/multiplier.sv | 17 +
 rtl/bch_bm_solver.sv | 102 ++++++++++
 tb/tb_bch_bm_solver.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bch_pkg.sv
// bch_pkg: shared field parameters and BM solver state encoding for the t=12 BCH decoder
package bch_pkg;
    localparam int M = 16;
    localparam int T = 12;
    localparam int NSYN = 2 * T;
    localparam logic [M:0] POLY = 17'h1002D;
    typedef enum logic [1:0] {IDLE, DISC, UPDT, DONE} bm_state_t;
endpackage

// File: rtl/multiplier.sv
// multiplier: combinational GF(2^16) multiply modulo x^16+x^5+x^3+x^2+1
module multiplier
    import bch_pkg::*;
(
    input  logic [M-1:0] DinA,
    input  logic [M-1:0] DinB,
    input  logic         enmultiply,
    output logic [M-1:0] POBA
);
    logic [M-1:0] p;
    always_comb begin
        p = '0;
        for (int i = M - 1; i >= 0; i--)
            p = {p[M-2:0], 1'b0} ^ (p[M-1] ? POLY[M-1:0] : '0) ^ (DinB[i] ? DinA : '0);
        POBA = enmultiply ? p : '0;
    end
endmodule

// File: rtl/bch_bm_solver.sv
// bch_bm_solver: binary simplified inversionless Berlekamp-Massey solver, two cycles per iteration
module bch_bm_solver
    import bch_pkg::*;
(
    input  logic              clkofbm,
    input  logic              rstofbm,
    input  logic              startbm,
    input  logic [NSYN*M-1:0] syndrome,
    output logic [M-1:0]      miu0,
    output logic [M-1:0]      miu1,
    output logic [M-1:0]      miu2,
    output logic [M-1:0]      miu3,
    output logic [M-1:0]      miu4,
    output logic [M-1:0]      miu5,
    output logic [M-1:0]      miu6,
    output logic [M-1:0]      miu7,
    output logic [M-1:0]      miu8,
    output logic [M-1:0]      miu9,
    output logic [M-1:0]      miu10,
    output logic [M-1:0]      miu11,
    output logic [M-1:0]      miu12,
    output logic              bmvalid,
    output logic              bmbusy,
    output logic [3:0]        locdeg
);
    bm_state_t state, state_nx;
    logic [NSYN-1:0][M-1:0] syn;
    logic [T:0][M-1:0] lam, b, lam_nx, xb, dsel, dprod, glam, db;
    logic [M-1:0] gam, delta, delta_nx;
    logic signed [5:0] k;
    logic [3:0] r, deg_nx;
    logic [4:0] r2;
    logic accept, last, swap;

    assign accept = startbm && (state == IDLE || state == DONE);
    assign last = r == 4'(T - 1);
    assign swap = delta != '0 && !k[5];
    assign r2 = {r, 1'b0};
    assign xb = {b[T-1:0], {M{1'b0}}};

    always_ff @(posedge clkofbm) state <= rstofbm ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        if (accept) state_nx = DISC;
        else if (state == DISC) state_nx = UPDT;
        else if (state == UPDT) state_nx = last ? DONE : DISC;
    end

    generate
        for (genvar i = 0; i <= T; i++) begin : g_coef
            // S_(2r+1-i) lives at syn[2r-i]; indices below S1 read as zero
            assign dsel[i] = r2 >= 5'(i) ? syn[r2 - 5'(i)] : '0;
            multiplier u_disc (.DinA(lam[i]), .DinB(dsel[i]), .enmultiply(1'b1), .POBA(dprod[i]));
            multiplier u_glam (.DinA(gam), .DinB(lam[i]), .enmultiply(1'b1), .POBA(glam[i]));
            multiplier u_dxb (.DinA(delta), .DinB(xb[i]), .enmultiply(1'b1), .POBA(db[i]));
            assign lam_nx[i] = glam[i] ^ db[i];
        end
    endgenerate

    always_comb begin
        delta_nx = '0;
        deg_nx = '0;
        for (int i = 0; i <= T; i++) begin
            delta_nx = delta_nx ^ dprod[i];
            deg_nx = lam_nx[i] != '0 ? 4'(i) : deg_nx;
        end
    end

    always_ff @(posedge clkofbm) begin
        if (rstofbm) begin
            syn <= '0;
            lam <= '0;
            b <= '0;
            gam <= '0;
            delta <= '0;
            k <= '0;
            r <= '0;
            locdeg <= '0;
        end else if (accept) begin
            syn <= syndrome;
            lam <= {{T*M{1'b0}}, M'(1)};
            b <= {{T*M{1'b0}}, M'(1)};
            gam <= M'(1);
            k <= '0;
            r <= '0;
        end else if (state == DISC) begin
            delta <= delta_nx;
        end else if (state == UPDT) begin
            lam <= lam_nx;
            b <= swap ? {lam[T-1:0], {M{1'b0}}} : {b[T-2:0], {2*M{1'b0}}};
            gam <= swap ? delta : gam;
            k <= swap ? ~k : k + 6'sd1;
            r <= last ? r : r + 4'd1;
            locdeg <= last ? deg_nx : locdeg;
        end
    end

    assign bmvalid = state == DONE;
    assign bmbusy = state == DISC || state == UPDT;
    assign {miu12, miu11, miu10, miu9, miu8, miu7, miu6, miu5, miu4, miu3, miu2, miu1, miu0} = lam;
endmodule

// File: tb/tb_bch_bm_solver.sv
// tb_bch_bm_solver: checks the BM solver against locators built directly from known error values
module tb_bch_bm_solver;
    localparam int M = 16;
    localparam int NSYN = 24;
    localparam int NQ = 65535;

    logic clkofbm = 0, rstofbm = 1, startbm = 0;
    logic [NSYN*M-1:0] syndrome = '0;
    logic [M-1:0] miu [13];
    logic bmvalid, bmbusy;
    logic [3:0] locdeg;

    always #5 clkofbm = ~clkofbm;

    bch_bm_solver dut (
        .clkofbm(clkofbm), .rstofbm(rstofbm), .startbm(startbm), .syndrome(syndrome),
        .miu0(miu[0]), .miu1(miu[1]), .miu2(miu[2]), .miu3(miu[3]), .miu4(miu[4]),
        .miu5(miu[5]), .miu6(miu[6]), .miu7(miu[7]), .miu8(miu[8]), .miu9(miu[9]),
        .miu10(miu[10]), .miu11(miu[11]), .miu12(miu[12]),
        .bmvalid(bmvalid), .bmbusy(bmbusy), .locdeg(locdeg)
    );

    logic [M-1:0] alog [NQ];
    int lg [NQ+1];
    logic [M-1:0] loc_v [13], pend_loc [13], exp_loc [13];
    logic [NSYN*M-1:0] syn_v;
    int errs [12];
    int nerr = 0, pend_deg = 0, exp_deg = 0, mcnt = 0, lit_req = 0;
    int n_chk = 0, n_fail = 0;
    bit mvalid = 0, mbusy = 0, chk_en = 0;

    function automatic logic [M-1:0] gmul(input logic [M-1:0] a, input logic [M-1:0] c);
        if (a == 0 || c == 0) return '0;
        return alog[(lg[a] + lg[c]) % NQ];
    endfunction

    function automatic logic [M-1:0] apow(input int p);
        return alog[p % NQ];
    endfunction

    // syndromes S_j = sum beta^j and locator prod (1 + beta x) for errs[0..n-1]
    task automatic build(input int n);
        logic [M-1:0] s;
        nerr = n;
        syn_v = '0;
        for (int j = 1; j <= NSYN; j++) begin
            s = '0;
            for (int e = 0; e < n; e++) s = s ^ apow(errs[e] * j);
            syn_v[16*j-1 -: 16] = s;
        end
        for (int i = 0; i < 13; i++) loc_v[i] = (i == 0) ? 16'd1 : 16'd0;
        for (int e = 0; e < n; e++)
            for (int i = 12; i >= 1; i--) loc_v[i] = loc_v[i] ^ gmul(apow(errs[e]), loc_v[i-1]);
    endtask

    task automatic step();
        @(posedge clkofbm);
        #1;
    endtask

    task automatic start_run(input int n);
        syndrome = syn_v;
        pend_loc = loc_v;
        pend_deg = n;
        startbm = 1;
        step();
        startbm = 0;
        syndrome = ~syn_v;
    endtask

    task automatic wait_done();
        repeat (40) begin
            step();
            if (mvalid) break;
        end
    endtask

    task automatic lit(input int code);
        lit_req = code;
        step();
        lit_req = 0;
    endtask

    // reference timing: 24 edges from an accepted start to a held result
    always @(posedge clkofbm) begin
        if (rstofbm) begin
            mvalid = 0;
            mbusy = 0;
            mcnt = 0;
        end else if (startbm && !mbusy) begin
            mbusy = 1;
            mvalid = 0;
            mcnt = 0;
            exp_loc = pend_loc;
            exp_deg = pend_deg;
        end else if (mbusy) begin
            mcnt++;
            if (mcnt == 24) begin
                mbusy = 0;
                mvalid = 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    always @(negedge clkofbm) begin
        if (chk_en) begin
            logic [M-1:0] v, x;
            chk("bmvalid", 32'(bmvalid), 32'(mvalid));
            chk("bmbusy", 32'(bmbusy), 32'(mbusy));
            if (mvalid) begin
                chk("locdeg", 32'(locdeg), 32'(exp_deg));
                chk("miu0 nonzero", 32'(miu[0] != 0), 32'd1);
                for (int i = 1; i < 13; i++)
                    chk($sformatf("miu%0d scaled", i), 32'(miu[i]), 32'(gmul(miu[0], exp_loc[i])));
            end
            if (lit_req == 1) begin
                for (int i = 0; i < 13; i++) chk($sformatf("reset miu%0d", i), 32'(miu[i]), 32'd0);
                chk("reset locdeg", 32'(locdeg), 32'd0);
                chk("reset bmvalid", 32'(bmvalid), 32'd0);
                chk("reset bmbusy", 32'(bmbusy), 32'd0);
            end
            if (lit_req == 2) begin
                chk("pin alpha15", 32'(alog[15]), 32'h8000);
                chk("pin alpha16", 32'(alog[16]), 32'h002D);
                chk("pin mul a2a3", 32'(gmul(16'h0004, 16'h0008)), 32'h0020);
                chk("pin mul a8a12", 32'(gmul(16'h0100, 16'h1000)), 32'h02D0);
            end
            if (lit_req == 3) begin
                chk("zero miu0", 32'(miu[0]), 32'd1);
                for (int i = 1; i < 13; i++) chk($sformatf("zero miu%0d", i), 32'(miu[i]), 32'd0);
                chk("zero locdeg", 32'(locdeg), 32'd0);
            end
            if (lit_req == 4) begin
                chk("single loc model", 32'(exp_loc[1]), 32'h0020);
                chk("single miu1", 32'(miu[1]), 32'(gmul(miu[0], 16'h0020)));
                chk("single miu2", 32'(miu[2]), 32'd0);
                chk("single locdeg", 32'(locdeg), 32'd1);
            end
            if (lit_req == 5) begin
                for (int e = 0; e < nerr; e++) begin
                    x = apow(NQ - errs[e]);
                    v = '0;
                    for (int i = 12; i >= 0; i--) v = gmul(v, x) ^ miu[i];
                    chk($sformatf("root %0d", e), 32'(v), 32'd0);
                end
            end
        end
    end

    initial begin
        bit dup;
        alog[0] = 16'd1;
        for (int i = 1; i < NQ; i++)
            alog[i] = alog[i-1][M-1] ? ({alog[i-1][M-2:0], 1'b0} ^ 16'h002D) : {alog[i-1][M-2:0], 1'b0};
        lg[0] = 0;
        for (int i = 0; i < NQ; i++) lg[alog[i]] = i;
        repeat (3) step();
        rstofbm = 0;
        chk_en = 1;
        lit(1);
        lit(2);
        build(0);
        start_run(0);
        wait_done();
        lit(3);
        errs[0] = 5;
        build(1);
        start_run(1);
        wait_done();
        lit(4);
        errs[0] = 3;
        errs[1] = 100;
        build(2);
        start_run(2);
        wait_done();
        step();
        for (int e = 0; e < 12; e++) begin
            do begin
                errs[e] = int'($urandom_range(0, NQ - 1));
                dup = 0;
                for (int f = 0; f < e; f++) dup = dup | (errs[f] == errs[e]);
            end while (dup);
        end
        build(12);
        start_run(12);
        wait_done();
        lit(5);
        // a second start at edge 10 must be ignored
        errs[0] = 7;
        build(1);
        start_run(1);
        repeat (9) step();
        errs[0] = 3;
        errs[1] = 100;
        build(2);
        start_run(2);
        wait_done();
        step();
        // reset at edge 10 aborts, then a fresh run completes
        errs[0] = 9;
        build(1);
        start_run(1);
        repeat (9) step();
        rstofbm = 1;
        step();
        rstofbm = 0;
        lit(1);
        start_run(1);
        wait_done();
        step();
        // restart in the first DONE cycle
        errs[0] = 3;
        errs[1] = 100;
        build(2);
        start_run(2);
        wait_done();
        errs[0] = 40000;
        build(1);
        start_run(1);
        wait_done();
        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
